// File: rtl/pts_pkg.sv
// Shared types and constants for the PTS burst sequencer on the MRAM read path.
package pts_pkg;

   localparam int unsigned PTS_DATA_W  = 16;
   localparam int unsigned PTS_TIMEOUT = 15;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_LOAD    = 3'd3,
      ST_SEND    = 3'd4,
      ST_NEXT    = 3'd5,
      ST_FINISH  = 3'd6
   } pts_ctrl_state_t;

endpackage

// File: rtl/pts_rd_timer.sv
// Read-wait watchdog: reloads on entry to the wait and counts down while waiting.
// expired is high once TIMEOUT wait cycles have elapsed since the reload.
module pts_rd_timer
   import pts_pkg::*;
#(
   parameter int unsigned TIMEOUT = PTS_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int unsigned    CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] count_r;

   // Down-counter that parks at zero until the next reload.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_r <= {CNT_W{1'b0}};
      end else if (load) begin
         count_r <= RELOAD;
      end else if (en && (count_r != {CNT_W{1'b0}})) begin
         count_r <= count_r - CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/pts_burst_ctrl.sv
// Burst sequencer: fetches burst_len MRAM words from base_addr and hands each
// to the PTS converter, waiting for end-of-transmission before the next read.
module pts_burst_ctrl
   import pts_pkg::*;
#(
   parameter int unsigned DATA_W  = PTS_DATA_W,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned LEN_W   = 5,
   parameter int unsigned TIMEOUT = PTS_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [LEN_W-1:0]  words_sent,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              mem_rd_valid,
   output logic              pts_load,
   output logic              pts_send_data,
   output logic [DATA_W-1:0] pts_data,
   input  logic              pts_eot
);

   localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   pts_ctrl_state_t   state_r, next_state_s;
   logic [ADDR_W-1:0] addr_r;
   logic [LEN_W-1:0]  len_r, words_sent_r;
   logic [DATA_W-1:0] pts_data_r;
   logic              abort_pend_r, err_r;
   logic              busy_r, done_r, mem_rd_en_r, pts_load_r, pts_send_data_r;
   logic              busy_s, done_s, mem_rd_en_s, pts_load_s, pts_send_data_s;
   logic              start_zero_s, last_word_s, tmr_expired_s;

   assign start_zero_s = (state_r == ST_IDLE) && start && (burst_len == {LEN_W{1'b0}});
   assign last_word_s  = (LEN_W'(words_sent_r + LEN_ONE) == len_r);

   pts_rd_timer #(.TIMEOUT(TIMEOUT)) u_rd_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (state_r == ST_RD_REQ),
      .en      (state_r == ST_RD_WAIT),
      .expired (tmr_expired_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; a read response beats a same-cycle timeout.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start && (burst_len != {LEN_W{1'b0}})) next_state_s = ST_RD_REQ;
            else                                       next_state_s = ST_IDLE;
         end
         ST_RD_REQ: next_state_s = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (mem_rd_valid)       next_state_s = ST_LOAD;
            else if (tmr_expired_s) next_state_s = ST_FINISH;
            else                    next_state_s = ST_RD_WAIT;
         end
         ST_LOAD: next_state_s = ST_SEND;
         ST_SEND: begin
            if (pts_eot) next_state_s = ST_NEXT;
            else         next_state_s = ST_SEND;
         end
         ST_NEXT: begin
            if (last_word_s || abort_pend_r || abort) next_state_s = ST_FINISH;
            else                                      next_state_s = ST_RD_REQ;
         end
         ST_FINISH: next_state_s = ST_IDLE;
         default:   next_state_s = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state so the strobes come out of flops.
   always_comb begin
      busy_s          = (next_state_s != ST_IDLE);
      mem_rd_en_s     = (next_state_s == ST_RD_REQ);
      pts_load_s      = (next_state_s == ST_LOAD);
      pts_send_data_s = (next_state_s == ST_SEND);
      done_s          = (next_state_s == ST_FINISH) || start_zero_s;
   end

   // Output strobe registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r          <= 1'b0;
         done_r          <= 1'b0;
         mem_rd_en_r     <= 1'b0;
         pts_load_r      <= 1'b0;
         pts_send_data_r <= 1'b0;
      end else begin
         busy_r          <= busy_s;
         done_r          <= done_s;
         mem_rd_en_r     <= mem_rd_en_s;
         pts_load_r      <= pts_load_s;
         pts_send_data_r <= pts_send_data_s;
      end
   end

   // Abort request held until the burst returns to idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         abort_pend_r <= 1'b0;
      end else begin
         abort_pend_r <= (state_r != ST_IDLE) && (abort_pend_r || abort);
      end
   end

   // Address, length, word count, captured data and sticky timeout flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_r       <= {ADDR_W{1'b0}};
         len_r        <= {LEN_W{1'b0}};
         words_sent_r <= {LEN_W{1'b0}};
         pts_data_r   <= {DATA_W{1'b0}};
         err_r        <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  err_r <= 1'b0;
                  if (burst_len != {LEN_W{1'b0}}) begin
                     addr_r       <= base_addr;
                     len_r        <= burst_len;
                     words_sent_r <= {LEN_W{1'b0}};
                  end
               end
            end
            ST_RD_WAIT: begin
               if (mem_rd_valid)       pts_data_r <= mem_rd_data;
               else if (tmr_expired_s) err_r      <= 1'b1;
            end
            ST_NEXT: begin
               words_sent_r <= words_sent_r + LEN_ONE;
               if (next_state_s == ST_RD_REQ) addr_r <= addr_r + ADDR_ONE;
            end
            default: begin
               err_r <= err_r;
            end
         endcase
      end
   end

   assign busy          = busy_r;
   assign done          = done_r;
   assign err           = err_r;
   assign words_sent    = words_sent_r;
   assign mem_rd_en     = mem_rd_en_r;
   assign mem_addr      = addr_r;
   assign pts_load      = pts_load_r;
   assign pts_send_data = pts_send_data_r;
   assign pts_data      = pts_data_r;

endmodule
